// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with single-cycle ops plus iterative
// unsigned multiply/divide behind valid/ready handshakes on both sides.
module alu_multicycle #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] ALUop1,
    input  logic [DATA_WIDTH-1:0] ALUop2,
    input  logic [4:0]            ALUctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUout,
    output logic                  EQ
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(W);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state, w_next;
    logic [W-1:0]     r_opnd, r_out, w_simple, w_dsub;
    logic [2*W-1:0]   r_acc, w_acc_next;
    logic [CW-1:0]    r_cnt;
    logic             r_div, r_lo, r_eq, r_eq_pend;
    logic [W:0]       w_madd, w_shl;
    logic [SW-1:0]    w_shamt;
    logic             w_accept, w_long, w_div_in, w_last, w_eq, w_ge;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign ALUout    = r_out;
    assign EQ        = r_eq;

    assign w_accept = in_valid & in_ready;
    assign w_long   = (ALUctrl >= 5'd11) && (ALUctrl <= 5'd14);
    assign w_div_in = (ALUctrl >= 5'd13);
    assign w_eq     = (ALUop1 == ALUop2);
    assign w_shamt  = ALUop2[SW-1:0];
    assign w_last   = (r_cnt == CW'(W - 1));

    always_comb begin
        w_simple = '0;
        case (ALUctrl)
            5'd0:    w_simple = ALUop1 + ALUop2;
            5'd1:    w_simple = ALUop1 - ALUop2;
            5'd2:    w_simple = ALUop1 & ALUop2;
            5'd3:    w_simple = ALUop1 | ALUop2;
            5'd5:    w_simple = ALUop1 ^ ALUop2;
            5'd6:    w_simple = ALUop1 << w_shamt;
            5'd7:    w_simple = ALUop1 >> w_shamt;
            5'd8:    w_simple = $signed(ALUop1) >>> w_shamt;
            5'd9:    w_simple = {{(W-1){1'b0}}, $signed(ALUop1) < $signed(ALUop2)};
            5'd10:   w_simple = {{(W-1){1'b0}}, ALUop1 < ALUop2};
            default: w_simple = '0;
        endcase
    end

    // r_acc: multiply = {partial product, remaining multiplier}; divide = {remainder, quotient/dividend}
    assign w_madd     = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_acc[0] ? r_opnd : {W{1'b0}}};
    assign w_shl      = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_ge       = (w_shl >= {1'b0, r_opnd});
    assign w_dsub     = w_shl[W-1:0] - r_opnd;
    assign w_acc_next = r_div ? {w_ge ? w_dsub : w_shl[W-1:0], r_acc[W-2:0], w_ge}
                              : {w_madd, r_acc[W-1:1]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? (w_long ? BUSY : DONE) : IDLE;
            BUSY:    w_next = w_last ? DONE : BUSY;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opnd    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_lo      <= 1'b0;
            r_eq_pend <= 1'b0;
            r_out     <= '0;
            r_eq      <= 1'b0;
        end else if (w_accept) begin
            r_opnd    <= w_div_in ? ALUop2 : ALUop1;
            r_acc     <= {{W{1'b0}}, w_div_in ? ALUop1 : ALUop2};
            r_cnt     <= '0;
            r_div     <= w_div_in;
            r_lo      <= ALUctrl[0];
            r_eq_pend <= w_eq;
            if (!w_long) begin
                r_out <= w_simple;
                r_eq  <= w_eq;
            end
        end else if (r_state == BUSY) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_out <= r_lo ? w_acc_next[W-1:0] : w_acc_next[2*W-1:W];
                r_eq  <= r_eq_pend;
            end
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle covering single-cycle ops,
// iterative mul/div latency, backpressure, handshake turnaround and mid-op reset.
module tb_alu_multicycle;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] ALUop1 = '0;
    logic [W-1:0] ALUop2 = '0;
    logic [4:0]   ALUctrl = '0;
    logic         in_ready, out_valid, EQ;
    logic [W-1:0] ALUout;

    typedef struct packed {
        logic [W-1:0] res;
        logic         eq;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_multicycle #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
        .out_valid(out_valid), .out_ready(out_ready), .ALUout(ALUout), .EQ(EQ)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] c);
        logic [2*W-1:0] p;
        logic [W-1:0]   r;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (c)
            5'd0:    r = a + b;
            5'd1:    r = a - b;
            5'd2:    r = a & b;
            5'd3:    r = a | b;
            5'd5:    r = a ^ b;
            5'd6:    r = a << b[4:0];
            5'd7:    r = a >> b[4:0];
            5'd8:    r = $signed(a) >>> b[4:0];
            5'd9:    r = ($signed(a) < $signed(b)) ? 1 : 0;
            5'd10:   r = (a < b) ? 1 : 0;
            5'd11:   r = p[W-1:0];
            5'd12:   r = p[2*W-1:W];
            5'd13:   r = (b == 0) ? '1 : a / b;
            5'd14:   r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return {r, a == b};
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] c,
                         input logic [W-1:0] res, input logic eq);
        int t = 0;
        while (in_ready !== 1'b1 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL issue_ready got %b want 1", in_ready);
        end
        ALUop1 = a; ALUop2 = b; ALUctrl = c; in_valid = 1'b1;
        sb.push_back({res, eq});
        @(posedge clk); #1;
        in_valid = 1'b0;
        ALUop1 = $urandom; ALUop2 = $urandom; ALUctrl = 5'($urandom);
    endtask

    task automatic collect(input string name, input int exp_lat);
        int   lat = 1;
        int   rdy = 0;
        exp_t e;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) rdy++;
            @(posedge clk); #1; lat++;
        end
        n_vec++;
        if (lat != exp_lat) begin
            n_err++;
            $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
        end
        n_vec++;
        if (rdy != 0) begin
            n_err++;
            $display("FAIL %s busy_in_ready got %0d cycles high want 0", name, rdy);
        end
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        n_vec++;
        if (ALUout !== e.res || EQ !== e.eq) begin
            n_err++;
            $display("FAIL %s result got %h/%b want %h/%b", name, ALUout, EQ, e.res, e.eq);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s release got ov=%b ir=%b want ov=0 ir=1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ALUout !== '0 || EQ !== 1'b0) begin
            n_err++;
            $display("FAIL reset got ir=%b ov=%b out=%h eq=%b want 1 0 0 0", in_ready, out_valid, ALUout, EQ);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        issue(32'd5, 32'd7, 5'd0, 32'd12, 1'b0);
        collect("add", 1);
    endtask

    task automatic test_alu();
        issue(32'd9, 32'd9, 5'd1, 32'd0, 1'b1);                   collect("sub", 1);
        issue(32'h8000_0000, 32'd4, 5'd8, 32'hF800_0000, 1'b0);   collect("sra", 1);
        issue(32'hFFFF_FFFF, 32'd1, 5'd9, 32'd1, 1'b0);           collect("slt", 1);
        issue(32'hFFFF_FFFF, 32'd1, 5'd10, 32'd0, 1'b0);          collect("sltu", 1);
        issue(32'd3, 32'd4, 5'd20, 32'd0, 1'b0);                  collect("ctrl20", 1);
        issue(32'h0000_00F0, 32'hFFFF_FFE4, 5'd6, 32'h0000_0F00, 1'b0); collect("sll_mask", 1);
    endtask

    task automatic test_mul();
        issue(32'hFFFF_FFFF, 32'd2, 5'd11, 32'hFFFF_FFFE, 1'b0);  collect("mul", 33);
        issue(32'hFFFF_FFFF, 32'd2, 5'd12, 32'd1, 1'b0);          collect("mulhu", 33);
        issue(32'd77, 32'd77, 5'd11, 32'd5929, 1'b1);             collect("mul_eq", 33);
    endtask

    task automatic test_div();
        issue(32'd100, 32'd7, 5'd13, 32'd14, 1'b0);               collect("divu", 33);
        issue(32'd100, 32'd7, 5'd14, 32'd2, 1'b0);                collect("remu", 33);
        issue(32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1'b0);          collect("divu0", 33);
        issue(32'd5, 32'd0, 5'd14, 32'd5, 1'b0);                  collect("remu0", 33);
        issue(32'hFFFF_FFFF, 32'd1, 5'd13, 32'hFFFF_FFFF, 1'b0);  collect("divu_big", 33);
    endtask

    task automatic test_random();
        exp_t e;
        logic [W-1:0] a, b;
        logic [4:0] c;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = (i % 5 == 0) ? a : $urandom;
            c = (i < 32) ? 5'(i) : 5'($urandom_range(0, 14));
            e = model(a, b, c);
            issue(a, b, c, e.res, e.eq);
            collect("rand", (c >= 5'd11 && c <= 5'd14) ? 33 : 1);
        end
    endtask

    task automatic test_backpressure();
        int t = 0;
        int bad = 0;
        issue(32'd3, 32'd3, 5'd0, 32'd6, 1'b1);
        while (out_valid !== 1'b1 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; ALUop1 = $urandom; ALUop2 = $urandom; ALUctrl = 5'd1;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || ALUout !== 32'd6 || EQ !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL backpressure_hold got %0d unstable cycles want 0", bad);
        end
        collect("bp", 1);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bp_ignored got %0d spurious out_valid cycles want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int t = 0;
        exp_t e;
        issue(32'd1, 32'd2, 5'd0, 32'd3, 1'b0);
        while (out_valid !== 1'b1 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        n_vec++;
        if (ALUout !== e.res || EQ !== e.eq) begin
            n_err++;
            $display("FAIL b2b_first got %h/%b want %h/%b", ALUout, EQ, e.res, e.eq);
        end
        out_ready = 1'b1; in_valid = 1'b1; ALUop1 = 32'd4; ALUop2 = 32'd4; ALUctrl = 5'd0;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_no_accept got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
        issue(32'd4, 32'd4, 5'd0, 32'd8, 1'b1);
        collect("b2b_second", 1);
    endtask

    task automatic test_reset_mid();
        issue(32'hFFFF_FFFF, 32'd2, 5'd11, 32'hFFFF_FFFE, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUout !== '0 || EQ !== 1'b0) begin
            n_err++;
            $display("FAIL midreset got ov=%b ir=%b out=%h eq=%b want 0 1 0 0", out_valid, in_ready, ALUout, EQ);
        end
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_noresult got ov=%b want 0", out_valid);
        end
        issue(32'd1, 32'd1, 5'd0, 32'd2, 1'b1);
        collect("post_reset_add", 1);
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu();
        test_mul();
        test_div();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
